// File: rtl/wb_stage_pkg.sv
// ============================================================================
// Module   : wb_stage_pkg
// Purpose  : Shared widths and load-type encodings for the writeback stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_stage_pkg;

    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;
    localparam int RFREG_NUM   = 32;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_ext.sv
// ============================================================================
// Module   : wb_stage_load_ext
// Purpose  : Selects and extends load data from the raw memory word and
//            flags misaligned halfword/word accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage_load_ext #(
    parameter int XLEN = wb_stage_pkg::XLEN
) (
    input  logic [31:0]     rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      ldtype,
    output logic [XLEN-1:0] data,
    output logic            misalign
);
    import wb_stage_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Misaligned accesses return zero so nothing stale leaks to the register file.
    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (ldtype)
            LT_LB:  data = XLEN'($signed(w_byte));
            LT_LBU: data = XLEN'(w_byte);
            LT_LH: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data     = XLEN'($signed(w_half));
            end
            LT_LHU: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data     = XLEN'(w_half);
            end
            default: begin
                if (addr_lo != 2'b00) misalign = 1'b1;
                else                  data     = XLEN'(rdata);
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Purpose  : MEM/WB pipeline register, load extension, register-file write
//            port and forwarding tap. Define WB_INSTRET_EN to add the
//            retired-instruction counter output instret.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int XLEN        = wb_stage_pkg::XLEN,
    parameter int RFIDX_WIDTH = wb_stage_pkg::RFIDX_WIDTH
`ifdef WB_INSTRET_EN
    ,
    parameter int CNT_WIDTH   = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   mem_valid,
    input  logic [31:0]            mem_pc,
    input  logic                   mem_regwrite,
    input  logic                   mem_memtoreg,
    input  logic [RFIDX_WIDTH-1:0] mem_rd,
    input  logic [XLEN-1:0]        mem_alures,
    input  logic [31:0]            mem_rdata,
    input  logic [1:0]             mem_addr_lo,
    input  logic [2:0]             mem_ldtype,
    input  logic                   wb_stall,
    input  logic                   wb_flush,
    output logic                   we3,
    output logic [RFIDX_WIDTH-1:0] wa3,
    output logic [XLEN-1:0]        wd3,
    output logic [31:0]            pc,
    output logic                   wb_fwd_valid,
    output logic [RFIDX_WIDTH-1:0] wb_fwd_rd,
    output logic [XLEN-1:0]        wb_fwd_data,
    output logic                   wb_misalign
`ifdef WB_INSTRET_EN
    ,
    output logic [CNT_WIDTH-1:0]   instret
`endif
);
    import wb_stage_pkg::*;

    logic                   v_q, v_d;
    logic [31:0]            pc_q, pc_d;
    logic [RFIDX_WIDTH-1:0] rd_q, rd_d;
    logic                   regwrite_q, regwrite_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic                   misalign_q, misalign_d;
    logic                   done_q, done_d;

    logic [XLEN-1:0]        w_ext_data;
    logic                   w_ext_misalign;
    logic                   w_fwd_valid;
    logic                   w_we;

    wb_stage_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata    (mem_rdata),
        .addr_lo  (mem_addr_lo),
        .ldtype   (mem_ldtype),
        .data     (w_ext_data),
        .misalign (w_ext_misalign)
    );

    assign w_fwd_valid = v_q & regwrite_q & (rd_q != '0) & ~misalign_q;
    assign w_we        = w_fwd_valid & ~done_q;

    // Flush beats stall; a stalled instruction writes only on its first WB cycle.
    always_comb begin
        v_d        = v_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        data_d     = data_q;
        misalign_d = misalign_q;
        done_d     = done_q;
        if (wb_flush) begin
            v_d        = 1'b0;
            misalign_d = 1'b0;
            done_d     = 1'b0;
        end else if (wb_stall) begin
            done_d = done_q | w_we;
        end else begin
            v_d        = mem_valid;
            pc_d       = mem_pc;
            rd_d       = mem_rd;
            regwrite_d = mem_regwrite;
            data_d     = mem_memtoreg ? w_ext_data : mem_alures;
            misalign_d = mem_memtoreg & w_ext_misalign;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q        <= 1'b0;
            pc_q       <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            data_q     <= '0;
            misalign_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            v_q        <= v_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
            done_q     <= done_d;
        end
    end

    assign we3          = w_we;
    assign wa3          = rd_q;
    assign wd3          = data_q;
    assign pc           = pc_q;
    assign wb_fwd_valid = w_fwd_valid;
    assign wb_fwd_rd    = rd_q;
    assign wb_fwd_data  = data_q;
    assign wb_misalign  = v_q & misalign_q;

`ifdef WB_INSTRET_EN
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    // An instruction retires when its WB slot is released by capture or flush.
    always_comb begin
        instret_d = instret_q;
        if (v_q && (!wb_stall || wb_flush)) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) instret_q <= '0;
        else       instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed and random checks of wb_stage against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_valid, mem_regwrite, mem_memtoreg;
    logic [31:0] mem_pc, mem_alures, mem_rdata;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_addr_lo;
    logic [2:0]  mem_ldtype;
    logic        wb_stall, wb_flush;
    logic        we3, wb_fwd_valid, wb_misalign;
    logic [4:0]  wa3, wb_fwd_rd;
    logic [31:0] wd3, pc, wb_fwd_data;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    always #5 clk = ~clk;

    wb_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .mem_valid    (mem_valid),
        .mem_pc       (mem_pc),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_rd       (mem_rd),
        .mem_alures   (mem_alures),
        .mem_rdata    (mem_rdata),
        .mem_addr_lo  (mem_addr_lo),
        .mem_ldtype   (mem_ldtype),
        .wb_stall     (wb_stall),
        .wb_flush     (wb_flush),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .pc           (pc),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .wb_misalign  (wb_misalign)
`ifdef WB_INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the instruction currently sitting in WB.
    logic        m_v, m_rw, m_mis, m_written, m_known;
    logic [31:0] m_pc, m_data;
    logic [4:0]  m_rd;
    logic [63:0] m_instret;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Load result computed arithmetically from the byte offset and access size.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [2:0] lt, output logic mis);
        int unsigned b, h;
        b   = (w >> (8 * lo)) & 32'hFF;
        h   = (w >> (16 * (lo / 2))) & 32'hFFFF;
        mis = 1'b0;
        case (lt)
            3'b000: return (b >= 128) ? b - 256 : b;
            3'b100: return b;
            3'b001, 3'b101: begin
                if (lo % 2 != 0) begin mis = 1'b1; return 0; end
                if (lt == 3'b001 && h >= 32768) return h - 65536;
                return h;
            end
            default: begin
                if (lo != 0) begin mis = 1'b1; return 0; end
                return w;
            end
        endcase
    endfunction

    task automatic model_step();
        logic ewe, mis;
        logic [31:0] ld;
        ewe = m_v && m_rw && (m_rd != 0) && !m_mis && !m_written;
        if (!rstn) begin
            m_v = 0; m_rw = 0; m_mis = 0; m_written = 0; m_known = 1;
            m_pc = 0; m_data = 0; m_rd = 0; m_instret = 0;
        end else begin
            if (m_v && (!wb_stall || wb_flush)) m_instret = m_instret + 1;
            if (wb_flush) begin
                m_v = 0; m_mis = 0; m_written = 0; m_known = 0;
            end else if (wb_stall) begin
                if (ewe) m_written = 1;
            end else begin
                m_v = mem_valid; m_pc = mem_pc; m_rd = mem_rd; m_rw = mem_regwrite;
                if (mem_memtoreg) begin
                    ld = ref_load(mem_rdata, mem_addr_lo, mem_ldtype, mis);
                    m_data = ld; m_mis = mis;
                end else begin
                    m_data = mem_alures; m_mis = 0;
                end
                m_written = 0; m_known = 1;
            end
        end
    endtask

    task automatic check_model();
        logic efwd;
        efwd = m_v && m_rw && (m_rd != 0) && !m_mis;
        chk("we3", we3, efwd && !m_written);
        chk("fwd_valid", wb_fwd_valid, efwd);
        chk("misalign", wb_misalign, m_v && m_mis);
        if (m_known) begin
            chk("wa3", wa3, m_rd);
            chk("wd3", wd3, m_data);
            chk("pc", pc, m_pc);
            chk("fwd_rd", wb_fwd_rd, m_rd);
            chk("fwd_data", wb_fwd_data, m_data);
        end
`ifdef WB_INSTRET_EN
        chk("instret", instret, m_instret);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic rw, input logic mtr,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [1:0] lo, input logic [2:0] lt, input logic st, input logic fl);
        mem_valid = v; mem_pc = p; mem_regwrite = rw; mem_memtoreg = mtr; mem_rd = rd;
        mem_alures = alu; mem_rdata = rdat; mem_addr_lo = lo; mem_ldtype = lt;
        wb_stall = st; wb_flush = fl;
    endtask

    initial begin
        int nwe, nfwd;
        m_v = 0; m_rw = 0; m_mis = 0; m_written = 0; m_known = 0;
        m_pc = 0; m_data = 0; m_rd = 0; m_instret = 0;
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("reset_we3", we3, 0);
        chk("reset_wd3", wd3, 0);
        rstn = 1'b1;

        // LB / LBU of the top byte
        drive(1, 32'h100, 1, 1, 5, 0, 32'h80FF7F01, 2'd3, 3'b000, 0, 0);
        tick();
        chk("lb_we3", we3, 1);
        chk("lb_wa3", wa3, 5);
        chk("lb_wd3", wd3, 32'hFFFFFF80);
        drive(1, 32'h104, 1, 1, 5, 0, 32'h80FF7F01, 2'd3, 3'b100, 0, 0);
        tick();
        chk("lbu_wd3", wd3, 32'h00000080);

        // LH upper half, then misaligned LH
        drive(1, 32'h108, 1, 1, 6, 0, 32'h80011234, 2'd2, 3'b001, 0, 0);
        tick();
        chk("lh_wd3", wd3, 32'hFFFF8001);
        drive(1, 32'h10C, 1, 1, 6, 0, 32'h80011234, 2'd1, 3'b001, 0, 0);
        tick();
        chk("lh_mis_we3", we3, 0);
        chk("lh_mis_flag", wb_misalign, 1);
        chk("lh_mis_fwd", wb_fwd_valid, 0);

        // ALU result held through a three-cycle stall: one write, four forward cycles
        drive(1, 32'h110, 1, 0, 7, 32'h1234, 0, 0, 0, 0, 0);
        tick();
        nwe  = int'(we3);
        nfwd = int'(wb_fwd_valid);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hDEAD, 1, 0, 9, 32'hBEEF, 0, 0, 0, 1, 0);
            tick();
            nwe  += int'(we3);
            nfwd += int'(wb_fwd_valid);
            chk("stall_wd3", wd3, 32'h1234);
        end
        chk("stall_writes", nwe, 1);
        chk("stall_fwd_cycles", nfwd, 4);

        // x0 destination, then flush together with stall
        drive(1, 32'h114, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0);
        tick();
        chk("x0_we3", we3, 0);
        chk("x0_fwd", wb_fwd_valid, 0);
        drive(1, 32'h118, 1, 0, 3, 32'h66, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h11C, 1, 0, 4, 32'h77, 0, 0, 0, 1, 1);
        tick();
        chk("flush_we3", we3, 0);
        chk("flush_fwd", wb_fwd_valid, 0);

        // Reset during a stalled load
        drive(1, 32'h120, 1, 1, 9, 0, 32'hCAFEF00D, 2'd0, 3'b010, 0, 0);
        tick();
        drive(1, 32'h124, 1, 1, 9, 0, 32'hCAFEF00D, 2'd0, 3'b010, 1, 0);
        rstn = 1'b0;
        tick();
        chk("rst_we3", we3, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_pc", pc, 0);
        chk("rst_fwd", wb_fwd_valid, 0);
        chk("rst_fwd_data", wb_fwd_data, 0);
        chk("rst_mis", wb_misalign, 0);
        rstn = 1'b1;
        drive(1, 32'h128, 1, 0, 3, 32'hABC, 0, 0, 0, 0, 0);
        tick();
        chk("after_rst_we3", we3, 1);
        chk("after_rst_wd3", wd3, 32'hABC);

`ifdef WB_INSTRET_EN
        // Ten instructions: the fifth is flushed in MEM, the third stalls two cycles in WB
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) begin
                drive(1, 32'(i * 4), 1, 0, 5'(i), 32'(i), 0, 0, 0, 1, 0);
                tick();
                tick();
            end
            drive(1, 32'(i * 4), 1, 0, 5'(i), 32'(i), 0, 0, 0, 0, (i == 5) ? 1'b1 : 1'b0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("instret_total", instret, 9);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rstn = ($urandom_range(0, 49) != 0);
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                  1'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom, 2'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
